// File: rtl/if_inst_buffer.sv
// if_inst_buffer: fetch-side instruction buffer between the PC calculator
// and decode. Requests are accepted against a synchronous instruction SRAM,
// and the read data is captured one cycle later. The {pc, inst} pairs are
// queued in a circular FIFO, and the head entry is offered to decode over a
// valid/ready handshake.
// Optional build macro IF_BUF_PERF_EN adds three 32-bit performance counters:
// stall cycles, discarded entries and accepted fetches.
module if_inst_buffer #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        fetch_allowin,
    input  logic [31:0] inst_sram_rdata,
    input  logic        flush,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst
`ifdef IF_BUF_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_fetch_cnt
`endif
);

    localparam logic [PTR_W+1:0] DEPTH_OCC = (PTR_W+2)'(DEPTH);

    logic [PTR_W:0]   count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pend;
    logic [31:0]      pend_pc;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];

    logic             req_fire;
    logic             push;
    logic             pop;
    logic [PTR_W+1:0] occupancy;

    // Handshake decode. The occupancy term counts the in-flight response,
    // so that every accepted request is guaranteed a free slot one cycle later.
    always_comb begin
        id_valid      = (count != '0);
        pop           = id_valid & id_ready & ~flush;
        push          = pend & ~flush;
        occupancy     = {1'b0, count} + {{(PTR_W+1){1'b0}}, pend}
                        - {{(PTR_W+1){1'b0}}, pop};
        fetch_allowin = (occupancy < DEPTH_OCC);
        req_fire      = req_valid & fetch_allowin & ~flush;
        id_pc         = id_valid ? pc_mem[rd_ptr]   : '0;
        id_inst       = id_valid ? inst_mem[rd_ptr] : '0;
    end

    // Track the single outstanding SRAM read and its PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    <= 1'b0;
            pend_pc <= '0;
        end else begin
            pend <= req_fire;
            if (req_fire) begin
                pend_pc <= req_pc;
            end
        end
    end

    // FIFO pointers and occupancy; a flush empties the buffer in one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

    // Entry storage. Entries are only read while they are counted valid,
    // so the storage is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= pend_pc;
            inst_mem[wr_ptr] <= inst_sram_rdata;
        end
    end

`ifdef IF_BUF_PERF_EN
    // Performance counters. They wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_fetch_cnt <= '0;
        end else begin
            if (req_valid && !fetch_allowin) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'(count) + 32'(pend);
            end
            if (req_fire) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
